// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// The master drives operands and start; the slave returns status and results.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf, zero
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: computes a - b - bin, DIGIT bits per clock, LSB first,
// with the borrow held in a register between digits.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic              clk,
  input logic              rst_n,
  serial_subtractor_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_chk
    $error("serial_subtractor: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sr, b_sr, res_sr;
  logic               brw;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   diff_q;
  logic               bout_q, ovf_q, zero_q;

  logic               last, accept;
  logic [DIGIT-1:0]   d;
  logic               c, bin_msb, bout_d;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]   res_nxt;

  assign last   = (cnt == CW'(N - 1));
  assign accept = bus.start && (state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = FIN;
      FIN:     state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ripple full-subtractor across one digit; bin_msb ends as the borrow into
  // the digit's top bit, which on the last digit is the borrow into bit WIDTH-1.
  always_comb begin
    d       = '0;
    c       = brw;
    bin_msb = brw;
    for (int i = 0; i < DIGIT; i++) begin
      bin_msb = c;
      d[i]    = a_sr[i] ^ b_sr[i] ^ c;
      c       = (~a_sr[i] & b_sr[i]) | (~(a_sr[i] ^ b_sr[i]) & c);
    end
    bout_d = c;
  end

  assign res_cat = {d, res_sr};
  assign res_nxt = res_cat[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (accept) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      brw    <= bus.bin;
      res_sr <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> DIGIT;
      b_sr   <= b_sr >> DIGIT;
      brw    <= bout_d;
      res_sr <= res_nxt;
      cnt    <= cnt + 1'b1;
      if (last) begin
        diff_q <= res_nxt;
        bout_q <= bout_d;
        ovf_q  <= bin_msb ^ bout_d;
        zero_q <= ~|res_nxt;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == FIN);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed, random, handshake corner cases and an
// exhaustive 4-bit sweep at three digit sizes, against an arithmetic model.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) m ();
  serial_subtractor_if #(.WIDTH(4)) e1 ();
  serial_subtractor_if #(.WIDTH(4)) e2 ();
  serial_subtractor_if #(.WIDTH(4)) e4 ();

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(m));
  serial_subtractor #(.WIDTH(4), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(e1));
  serial_subtractor #(.WIDTH(4), .DIGIT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(e2));
  serial_subtractor #(.WIDTH(4), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(e4));

  typedef struct packed {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       zero;
  } res_t;

  // Integer arithmetic: unsigned result sign gives borrow, signed range gives overflow.
  function automatic res_t model(int a, int b, int bin, int w);
    res_t r;
    int full, sa, sb, sfull;
    full   = a - b - bin;
    r.diff = 8'(full & ((1 << w) - 1));
    r.bout = (full < 0);
    sa     = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb     = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    sfull  = sa - sb - bin;
    r.ovf  = (sfull < -(1 << (w - 1))) || (sfull > (1 << (w - 1)) - 1);
    r.zero = (r.diff == 8'h00);
    return r;
  endfunction

  // Launch one op on the 8-bit DUT, scramble inputs after the start edge and
  // wait (bounded) for done. Returns start-to-done latency and busy cycle count.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output int lat, output int bsy);
    m.start = 1'b1; m.a = a; m.b = b; m.bin = bin;
    @(posedge clk); #1;
    m.start = 1'b0;
    m.a = 8'($urandom); m.b = 8'($urandom); m.bin = 1'($urandom);
    lat = 0; bsy = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (m.busy) bsy++;
      @(posedge clk); #1;
      if (m.done) lat = k;
    end
  endtask

  task automatic test_reset();
    m.start = 0; m.a = 0; m.b = 0; m.bin = 0;
    e1.start = 0; e1.a = 0; e1.b = 0; e1.bin = 0;
    e2.start = 0; e2.a = 0; e2.b = 0; e2.bin = 0;
    e4.start = 0; e4.a = 0; e4.b = 0; e4.bin = 0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (m.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", m.busy); else n_pass++;
    n_chk++; if (m.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", m.done); else n_pass++;
    n_chk++; if (m.diff !== 8'h00) $display("FAIL reset_diff got=%h exp=00", m.diff); else n_pass++;
    n_chk++; if (m.bout !== 1'b0) $display("FAIL reset_bout got=%b exp=0", m.bout); else n_pass++;
    n_chk++; if (m.ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", m.ovf); else n_pass++;
    n_chk++; if (m.zero !== 1'b0) $display("FAIL reset_zero got=%b exp=0", m.zero); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [7:0] ta [5] = '{8'h5A, 8'h00, 8'h80, 8'h37, 8'h05};
    logic [7:0] tb [5] = '{8'h3C, 8'h01, 8'h01, 8'h36, 8'h03};
    logic       tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int lat, bsy;
    res_t r;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], tc[i], lat, bsy);
      r = model(ta[i], tb[i], tc[i], 8);
      n_chk++; if (lat !== 8) $display("FAIL dir_latency i=%0d got=%0d exp=8", i, lat); else n_pass++;
      n_chk++; if (bsy !== 8) $display("FAIL dir_busy_cycles i=%0d got=%0d exp=8", i, bsy); else n_pass++;
      n_chk++; if (m.busy !== 1'b0) $display("FAIL dir_busy_at_done i=%0d got=%b exp=0", i, m.busy); else n_pass++;
      n_chk++; if (m.diff !== r.diff) $display("FAIL dir_diff i=%0d got=%h exp=%h", i, m.diff, r.diff); else n_pass++;
      n_chk++; if (m.bout !== r.bout) $display("FAIL dir_bout i=%0d got=%b exp=%b", i, m.bout, r.bout); else n_pass++;
      n_chk++; if (m.ovf !== r.ovf) $display("FAIL dir_ovf i=%0d got=%b exp=%b", i, m.ovf, r.ovf); else n_pass++;
      n_chk++; if (m.zero !== r.zero) $display("FAIL dir_zero i=%0d got=%b exp=%b", i, m.zero, r.zero); else n_pass++;
      @(posedge clk); #1;
      n_chk++; if (m.done !== 1'b0) $display("FAIL dir_done_pulse i=%0d got=%b exp=0", i, m.done); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic bin;
    int lat, bsy;
    res_t r;
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      run_op(a, b, bin, lat, bsy);
      r = model(a, b, bin, 8);
      n_chk++; if (lat !== 8) $display("FAIL rnd_latency a=%h b=%h got=%0d exp=8", a, b, lat); else n_pass++;
      n_chk++; if ({m.diff, m.bout, m.ovf, m.zero} !== r)
        $display("FAIL rnd_result a=%h b=%h bin=%b got=%h/%b%b%b exp=%h/%b%b%b", a, b, bin,
                 m.diff, m.bout, m.ovf, m.zero, r.diff, r.bout, r.ovf, r.zero);
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int lat = 0;
    res_t r = model(8'h5A, 8'h3C, 0, 8);
    m.start = 1'b1; m.a = 8'h5A; m.b = 8'h3C; m.bin = 1'b0;
    @(posedge clk); #1;
    m.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m.start = 1'b1; m.a = 8'hFF; m.b = 8'h00; m.bin = 1'b1;
    @(posedge clk); #1;
    m.start = 1'b0;
    for (int k = 4; k <= 40 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (m.done) lat = k;
    end
    n_chk++; if (lat !== 8) $display("FAIL ign_latency got=%0d exp=8", lat); else n_pass++;
    n_chk++; if (m.diff !== r.diff) $display("FAIL ign_diff got=%h exp=%h", m.diff, r.diff); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (m.busy !== 1'b0) $display("FAIL ign_no_restart got=%b exp=0", m.busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] a = 8'($urandom), b = 8'($urandom);
    int lat, bsy;
    res_t r1 = model(a, b, 0, 8);
    res_t r2 = model(8'h10, 8'h20, 0, 8);
    run_op(a, b, 1'b0, lat, bsy);
    n_chk++; if (m.diff !== r1.diff) $display("FAIL b2b_first_diff got=%h exp=%h", m.diff, r1.diff); else n_pass++;
    m.start = 1'b1; m.a = 8'h10; m.b = 8'h20; m.bin = 1'b0;
    @(posedge clk); #1;
    m.start = 1'b0; m.a = 8'($urandom); m.b = 8'($urandom);
    n_chk++; if (m.busy !== 1'b1) $display("FAIL b2b_busy got=%b exp=1", m.busy); else n_pass++;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (k == 5) begin
        n_chk++; if (m.diff !== r1.diff) $display("FAIL b2b_hold got=%h exp=%h", m.diff, r1.diff); else n_pass++;
      end
      @(posedge clk); #1;
      if (m.done) lat = k;
    end
    n_chk++; if (lat !== 8) $display("FAIL b2b_latency got=%0d exp=8", lat); else n_pass++;
    n_chk++; if (m.diff !== r2.diff) $display("FAIL b2b_diff got=%h exp=%h", m.diff, r2.diff); else n_pass++;
    n_chk++; if (m.bout !== r2.bout) $display("FAIL b2b_bout got=%b exp=%b", m.bout, r2.bout); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int lat, bsy;
    bit saw_done = 0;
    res_t r = model(8'h05, 8'h03, 0, 8);
    run_op(8'h77, 8'h11, 1'b0, lat, bsy);
    m.start = 1'b1; m.a = 8'h12; m.b = 8'h34; m.bin = 1'b0;
    @(posedge clk); #1;
    m.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (m.busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", m.busy); else n_pass++;
    n_chk++; if (m.done !== 1'b0) $display("FAIL abort_done got=%b exp=0", m.done); else n_pass++;
    n_chk++; if (m.diff !== 8'h00) $display("FAIL abort_diff got=%h exp=00", m.diff); else n_pass++;
    n_chk++; if ({m.bout, m.ovf, m.zero} !== 3'b000)
      $display("FAIL abort_flags got=%b%b%b exp=000", m.bout, m.ovf, m.zero);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (m.done || m.busy) saw_done = 1;
    end
    n_chk++; if (saw_done !== 1'b0) $display("FAIL abort_no_done got=%b exp=0", saw_done); else n_pass++;
    run_op(8'h05, 8'h03, 1'b0, lat, bsy);
    n_chk++; if (lat !== 8) $display("FAIL abort_restart_latency got=%0d exp=8", lat); else n_pass++;
    n_chk++; if (m.diff !== r.diff) $display("FAIL abort_restart_diff got=%h exp=%h", m.diff, r.diff); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive();
    int   lat [3];
    int   exp_lat [3] = '{4, 2, 1};
    logic [6:0] got [3];
    res_t r;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          e1.start = 1; e1.a = 4'(a); e1.b = 4'(b); e1.bin = 1'(c);
          e2.start = 1; e2.a = 4'(a); e2.b = 4'(b); e2.bin = 1'(c);
          e4.start = 1; e4.a = 4'(a); e4.b = 4'(b); e4.bin = 1'(c);
          @(posedge clk); #1;
          e1.start = 0; e2.start = 0; e4.start = 0;
          e1.a = 4'($urandom); e2.b = 4'($urandom); e4.bin = 1'($urandom);
          lat = '{0, 0, 0};
          for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (e1.done && lat[0] == 0) lat[0] = k;
            if (e2.done && lat[1] == 0) lat[1] = k;
            if (e4.done && lat[2] == 0) lat[2] = k;
          end
          got[0] = {e1.diff, e1.bout, e1.ovf, e1.zero};
          got[1] = {e2.diff, e2.bout, e2.ovf, e2.zero};
          got[2] = {e4.diff, e4.bout, e4.ovf, e4.zero};
          r = model(a, b, c, 4);
          for (int j = 0; j < 3; j++) begin
            n_chk++;
            if (lat[j] !== exp_lat[j])
              $display("FAIL exh_latency inst=%0d a=%h b=%h bin=%0d got=%0d exp=%0d", j, a, b, c, lat[j], exp_lat[j]);
            else n_pass++;
            n_chk++;
            if (got[j] !== {r.diff[3:0], r.bout, r.ovf, r.zero})
              $display("FAIL exh_result inst=%0d a=%h b=%h bin=%0d got=%b exp=%b", j, a, b, c, got[j],
                       {r.diff[3:0], r.bout, r.ovf, r.zero});
            else n_pass++;
          end
        end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    test_exhaustive();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Parametrised multi-cycle subtractor computing A - B - BIN on WIDTH-bit operands. It processes DIGIT bits per clock, LSB digit first, and carries the borrow between cycles in a register. It trades latency for area in datapaths that need wide subtraction without a full-width ripple-borrow chain. Results are signalled with a START/BUSY/DONE handshake.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 2.
DIGIT, 1, bits processed per clock; must divide WIDTH exactly. N = WIDTH/DIGIT cycles per operation.

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
START  input  1  request; sampled only when BUSY=0
A  input  WIDTH  minuend, captured on accepted START
B  input  WIDTH  subtrahend, captured on accepted START
BIN  input  1  borrow-in, captured on accepted START
BUSY  output  1  operation in progress
DONE  output  1  one-cycle pulse; results valid and updated this cycle
DIFF  output  WIDTH  registered result A - B - BIN mod 2^WIDTH
BOUT  output  1  unsigned borrow-out of the MSB
OVF  output  1  two's-complement overflow
ZERO  output  1  DIFF == 0

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE; BUSY, DONE, DIFF, BOUT, OVF and ZERO are all 0; shift registers, borrow register and digit counter are cleared.
- States: IDLE, RUN, FIN.
  - IDLE/FIN + START=1 -> RUN: A, B and BIN are latched into the operand shift registers and the borrow register, and the counter is set to 0.
  - RUN: each edge processes one digit, with cnt incrementing. After processing digit N-1, the state goes to FIN.
  - FIN: lasts exactly one cycle. It returns to IDLE, or goes to RUN if START=1.
  - IDLE + START=0 -> IDLE.
- Timing:
  - START is sampled at edge t0, and BUSY=1 from t0 until edge t0+N.
  - Digit i is processed at edge t0+1+i, for i=0..N-1.
  - At edge t0+N the final digit result, BOUT, OVF and ZERO are written to the output registers.
  - DONE=1 and BUSY=0 in the cycle following edge t0+N. Latency from START to DONE is N cycles.
- Digit arithmetic: {borrow_out, d} = a_dig - b_dig - borrow_reg, where d is DIGIT bits wide. This is a DIGIT-wide full-subtractor chain, and borrow_out is registered for the next digit. The result digit shifts into an internal result register from the MSB side.
- BOUT = borrow out of bit WIDTH-1. OVF = borrow into bit WIDTH-1 XOR borrow out of bit WIDTH-1. ZERO is the NOR of the final DIFF.
- Output registers (DIFF, BOUT, OVF, ZERO) change only at the completion edge. They hold their values through IDLE and through subsequent RUN phases until the next completion.
- START while BUSY=1 is ignored: operands are not re-latched and timing is unaffected.
- START in the FIN cycle (BUSY=0, DONE=1) is accepted back-to-back. BUSY=1 the next cycle and no idle gap is required.
- Reset asserted mid-operation aborts immediately: all outputs read 0 and no DONE pulse is issued. The first START after reset release is handled normally.
- A, B and BIN may change freely after the START edge with no effect on the result.
- DIGIT=WIDTH degenerates to N=1: DONE is asserted one cycle after START.

Test Plan:
- WIDTH=8, DIGIT=1; A=0x5A, B=0x3C, BIN=0 -> DONE exactly 8 cycles after the START edge; DIFF=0x1E, BOUT=0, OVF=0, ZERO=0. BUSY high for 8 cycles.
- A=0x00, B=0x01, BIN=0 -> DIFF=0xFF, BOUT=1, OVF=0, ZERO=0. A=0x80, B=0x01, BIN=0 -> DIFF=0x7F, BOUT=0, OVF=1.
- A=0x37, B=0x36, BIN=1 -> DIFF=0x00, ZERO=1, BOUT=0, OVF=0. Change A/B on the cycle after START -> result unchanged.
- START pulsed with A=0xFF at cycle 3 of RUN -> ignored, first result intact. START held during the FIN cycle with A=0x10, B=0x20 -> second DONE 8 cycles later with DIFF=0xF0, BOUT=1. Previous outputs hold until then.
- Reset asserted during the 4th RUN cycle -> BUSY=DONE=DIFF=BOUT=OVF=ZERO=0 asynchronously, with no DONE pulse. After release, START with 0x05-0x03 -> DIFF=0x02 after 8 cycles.
- Exhaustive check at WIDTH=4 with DIGIT=1, 2 and 4: all 512 (A, B, BIN) combinations compared against a behavioural model (DIFF, BOUT, OVF, ZERO); DONE latency equals 4, 2 and 1 cycles respectively.
